pca9685_regfile: RTL



---
 rtl/pca9685_regfile.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pca9685_regfile.sv
// pca9685_regfile: PCA9685 register bank and PWM timebase behind the I2C target.
//   clk_i                   system clock
//   rst_ni                  asynchronous active-low reset
//   write_register_id_i     register address of the current write strobe
//   write_register_value_i  data byte of the current write strobe
//   write_enable_i          level write strobe, applied on every edge it is high
//   register_blob_o         256-byte register image, byte n at [n*8 +: 8], bit n*8 = MSB
//   pwm_count_o             PWM phase counter 0..4095
//   cycle_start_o           one-cycle pulse coincident with the 4095->0 wrap
//   running_o               high while the timebase is in RUN
module pca9685_regfile #(
  parameter int unsigned OSC_DIV     = 1,
  parameter int unsigned WAKE_CYCLES = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [7:0]    write_register_id_i,
  input  logic [7:0]    write_register_value_i,
  input  logic          write_enable_i,
  output logic [2047:0] register_blob_o,
  output logic [11:0]   pwm_count_o,
  output logic          cycle_start_o,
  output logic          running_o
);

  localparam int unsigned BLOB_W    = 2048;
  localparam int unsigned STORED    = 70;   // MODE1..LED15_OFF_H (0x00..0x45)
  localparam int unsigned LED_BASE  = 6;
  localparam int unsigned PRE_IDX   = 254;
  localparam int unsigned CNT_W     = 12;
  localparam int unsigned OSC_W     = (OSC_DIV > 1) ? $clog2(OSC_DIV) : 1;
  localparam int unsigned WAKE_W    = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  localparam logic [7:0] ADDR_ALL_FIRST = 8'hFA;
  localparam logic [7:0] ADDR_ALL_LAST  = 8'hFD;
  localparam logic [7:0] ADDR_PRESCALE  = 8'hFE;
  localparam logic [7:0] PRESCALE_MIN   = 8'h03;
  localparam logic [7:0] PRESCALE_RST   = 8'h1E;

  typedef enum logic [1:0] {
    ST_SLEEPING,
    ST_WAKING,
    ST_RUN
  } state_e;

  // Power-on value of stored byte n.
  function automatic logic [7:0] reset_value(input int unsigned n);
    logic [7:0] v;
    case (n)
      0:       v = 8'h11;
      1:       v = 8'h04;
      2:       v = 8'hE2;
      3:       v = 8'hE4;
      4:       v = 8'hE8;
      5:       v = 8'hE0;
      default: v = (n >= LED_BASE && ((n - LED_BASE) % 4) == 3) ? 8'h10 : 8'h00;
    endcase
    return v;
  endfunction

  // Stored form of a byte written to address n: RESTART never sticks, *_H keep 5 bits.
  function automatic logic [7:0] mask_value(input int unsigned n, input logic [7:0] v);
    logic [7:0] r;
    if (n == 0)
      r = v & 8'h7F;
    else if (n >= LED_BASE && (n % 2) == 1)
      r = v & 8'h1F;
    else
      r = v;
    return r;
  endfunction

  // Drop one byte into the image with bit n*8 as its MSB.
  function automatic logic [BLOB_W-1:0] place(input logic [BLOB_W-1:0] img,
                                              input int unsigned n,
                                              input logic [7:0] v);
    logic [BLOB_W-1:0] r;
    r = img;
    for (int unsigned b = 0; b < 8; b++) begin
      r[11'(n * 8 + b)] = v[3'(7 - b)];
    end
    return r;
  endfunction

  function automatic logic [BLOB_W-1:0] reset_image();
    logic [BLOB_W-1:0] r;
    r = '0;
    for (int unsigned n = 0; n < STORED; n++) begin
      r = place(r, n, reset_value(n));
    end
    r = place(r, PRE_IDX, PRESCALE_RST);
    return r;
  endfunction

  logic [7:0]        mem_q [STORED];
  logic [7:0]        mem_d [STORED];
  logic [7:0]        prescale_q;
  logic [7:0]        prescale_d;
  logic [BLOB_W-1:0] blob_q;
  logic [BLOB_W-1:0] image_c;
  logic              all_led_hit;
  logic [1:0]        all_led_off;
  logic              sleep_d;

  state_e            state_q,       state_d;
  logic [WAKE_W-1:0] wake_cnt_q,    wake_cnt_d;
  logic [OSC_W-1:0]  osc_cnt_q,     osc_cnt_d;
  logic [7:0]        pre_cnt_q,     pre_cnt_d;
  logic [CNT_W-1:0]  count_q,       count_d;
  logic              cycle_start_q, cycle_start_d;
  logic              running_q,     running_d;

  // ALL_LED_* broadcast: 0xFA..0xFD map to byte offsets 0..3 inside each channel.
  assign all_led_hit = write_enable_i &&
                       (write_register_id_i >= ADDR_ALL_FIRST) &&
                       (write_register_id_i <= ADDR_ALL_LAST);
  assign all_led_off = 2'(write_register_id_i[1:0] + 2'd2);

  // Next value of every stored byte.
  always_comb begin
    for (int unsigned n = 0; n < STORED; n++) begin
      mem_d[n] = mem_q[n];
      if (write_enable_i && write_register_id_i == 8'(n)) begin
        mem_d[n] = mask_value(n, write_register_value_i);
      end else if (all_led_hit && n >= LED_BASE && 2'(n - LED_BASE) == all_led_off) begin
        mem_d[n] = mask_value(n, write_register_value_i);
      end
    end
  end

  // PRE_SCALE only accepts writes while the stored MODE1 says SLEEP.
  always_comb begin
    prescale_d = prescale_q;
    if (write_enable_i && write_register_id_i == ADDR_PRESCALE && mem_q[0][4]) begin
      prescale_d = (write_register_value_i < PRESCALE_MIN) ? PRESCALE_MIN
                                                           : write_register_value_i;
    end
  end

  // Live image of the stored bytes; unmapped and write-only bytes stay zero.
  always_comb begin
    image_c = '0;
    for (int unsigned n = 0; n < STORED; n++) begin
      image_c = place(image_c, n, mem_q[n]);
    end
    image_c = place(image_c, PRE_IDX, prescale_q);
  end

  // Register storage plus a second stage feeding the blob output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned n = 0; n < STORED; n++) begin
        mem_q[n] <= reset_value(n);
      end
      prescale_q <= PRESCALE_RST;
      blob_q     <= reset_image();
    end else begin
      mem_q      <= mem_d;
      prescale_q <= prescale_d;
      blob_q     <= image_c;
    end
  end

  // SLEEP as it will be stored after this edge, so a sleeping write beats a same-edge wrap.
  assign sleep_d = mem_d[0][4];

  // Timebase state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_SLEEPING;
      wake_cnt_q    <= '0;
      osc_cnt_q     <= '0;
      pre_cnt_q     <= '0;
      count_q       <= '0;
      cycle_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wake_cnt_q    <= wake_cnt_d;
      osc_cnt_q     <= osc_cnt_d;
      pre_cnt_q     <= pre_cnt_d;
      count_q       <= count_d;
      cycle_start_q <= cycle_start_d;
      running_q     <= running_d;
    end
  end

  // Timebase next state: wake delay, then nested osc/prescale dividers clocking the phase counter.
  always_comb begin
    state_d       = state_q;
    wake_cnt_d    = wake_cnt_q;
    osc_cnt_d     = osc_cnt_q;
    pre_cnt_d     = pre_cnt_q;
    count_d       = count_q;
    cycle_start_d = 1'b0;
    running_d     = 1'b0;

    case (state_q)
      ST_SLEEPING: begin
        wake_cnt_d = '0;
        osc_cnt_d  = '0;
        pre_cnt_d  = '0;
        count_d    = '0;
        if (!sleep_d) begin
          state_d = ST_WAKING;
        end
      end

      ST_WAKING: begin
        if (sleep_d) begin
          state_d    = ST_SLEEPING;
          wake_cnt_d = '0;
        end else if (wake_cnt_q == WAKE_W'(WAKE_CYCLES - 1)) begin
          state_d    = ST_RUN;
          wake_cnt_d = '0;
          osc_cnt_d  = '0;
          pre_cnt_d  = '0;
          count_d    = '0;
          running_d  = 1'b1;
        end else begin
          wake_cnt_d = wake_cnt_q + WAKE_W'(1);
        end
      end

      ST_RUN: begin
        if (sleep_d) begin
          state_d   = ST_SLEEPING;
          osc_cnt_d = '0;
          pre_cnt_d = '0;
          count_d   = '0;
        end else begin
          running_d = 1'b1;
          if (osc_cnt_q == OSC_W'(OSC_DIV - 1)) begin
            osc_cnt_d = '0;
            if (pre_cnt_q == prescale_q) begin
              pre_cnt_d = '0;
              if (count_q == {CNT_W{1'b1}}) begin
                count_d       = '0;
                cycle_start_d = 1'b1;
              end else begin
                count_d = count_q + CNT_W'(1);
              end
            end else begin
              pre_cnt_d = pre_cnt_q + 8'd1;
            end
          end else begin
            osc_cnt_d = osc_cnt_q + OSC_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_SLEEPING;
      end
    endcase
  end

  assign register_blob_o = blob_q;
  assign pwm_count_o     = count_q;
  assign cycle_start_o   = cycle_start_q;
  assign running_o       = running_q;

endmodule
